shift_cmd_sequencer: RTL

Command front-end that sits directly upstream of the team's 8-bit load/store/shift register and drives its control inputs. Buffers shift/load commands in a small FIFO behind a valid/ready handshake. Executes each command as a sequence of single-step register operations. Captures the register output and returns it on a valid/ready result channel.

---
 rtl/shift_cmd_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/shift_cmd_sequencer.sv
// shift_cmd_sequencer: command front-end for the 8-bit load/store/shift
// register. Commands are queued in a small FIFO and executed one at a time
// as single-step register operations. The settled register value is then
// returned on a valid/ready result channel.
module shift_cmd_sequencer #(
    parameter int N     = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [N-1:0] cmd_data,
    input  logic [2:0]   cmd_cnt,
    input  logic         cmd_fill,
    output logic [1:0]   sh_ctrl,
    output logic [2:0]   sh_num,
    output logic [N-1:0] sh_in,
    output logic         sh_Ls,
    output logic         sh_Rs,
    input  logic [N-1:0] sh_out,
    output logic         res_valid,
    output logic [N-1:0] res_data,
    input  logic         res_ready,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC    = 2'd1,
        CAPTURE = 2'd2,
        RESULT  = 2'd3
    } state_t;

    localparam int W = 2 + N + 3 + 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    state_t state, state_next;

    logic [W-1:0]   mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic           push, pop;

    logic [1:0]     head_op;
    logic [N-1:0]   head_data;
    logic [2:0]     head_cnt;
    logic           head_fill;

    logic [1:0]     op_r;
    logic [N-1:0]   data_r;
    logic           fill_r;
    logic [2:0]     rem;

    assign cmd_ready = (count != FULL);
    assign push      = cmd_valid && cmd_ready;
    // Count is registered, so an entry written at one edge is only seen as
    // poppable from the next cycle on: no write-to-read bypass exists.
    assign pop       = (state == IDLE) && (count != '0);
    assign busy      = (state != IDLE) || (count != '0);

    assign {head_op, head_data, head_cnt, head_fill} = mem[rd_ptr];

    // FIFO storage write; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_op, cmd_data, cmd_cnt, cmd_fill};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Working registers: loaded on pop, shift counter steps down in EXEC.
    always_ff @(posedge clk) begin
        if (!clr) begin
            op_r   <= '0;
            data_r <= '0;
            fill_r <= 1'b0;
            rem    <= '0;
        end else if (pop) begin
            op_r   <= head_op;
            data_r <= head_data;
            fill_r <= head_fill;
            rem    <= head_cnt;
        end else if (state == EXEC && rem != '0) begin
            rem    <= rem - 3'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!clr) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state logic and register control outputs.
    always_comb begin
        state_next = state;
        sh_ctrl    = 2'b00;
        sh_num     = '0;
        sh_in      = '0;
        sh_Ls      = 1'b0;
        sh_Rs      = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) state_next = EXEC;
            end
            EXEC: begin
                case (op_r)
                    2'b01: begin
                        sh_ctrl    = 2'b01;
                        sh_in      = data_r;
                        state_next = CAPTURE;
                    end
                    2'b10, 2'b11: begin
                        if (rem == '0) begin
                            state_next = CAPTURE;
                        end else begin
                            sh_ctrl = op_r;
                            sh_num  = 3'd1;
                            sh_Ls   = fill_r;
                            sh_Rs   = fill_r;
                            if (rem == 3'd1) state_next = CAPTURE;
                        end
                    end
                    default: state_next = CAPTURE;
                endcase
            end
            CAPTURE: state_next = RESULT;
            RESULT: begin
                if (res_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Result channel: capture settled register output, hold until accepted.
    always_ff @(posedge clk) begin
        if (!clr) begin
            res_valid <= 1'b0;
            res_data  <= '0;
        end else if (state == CAPTURE) begin
            res_valid <= 1'b1;
            res_data  <= sh_out;
        end else if (state == RESULT && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule
